// File: rtl/mdu_div_iter.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Latency: XLEN busy cycles then a one-cycle done pulse; b==0 and signed overflow finish after one cycle.
// No backpressure: start is taken only in IDLE; the stall on busy|done blocks re-issue, kill aborts CALC.
module mdu_div_iter #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             kill,
   input  logic [1:0]       op,
   input  logic [XLEN-1:0]  a,
   input  logic [XLEN-1:0]  b,
   input  logic [TAG_W-1:0] rd_in,
   output logic             busy,
   output logic             done,
   output logic [XLEN-1:0]  result,
   output logic [TAG_W-1:0] rd_out
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   state_e             state_q, state_d;
   logic               sel_rem_q, sel_rem_d;   // op[1]: remainder wanted
   logic               neg_quo_q, neg_quo_d;
   logic               neg_rem_q, neg_rem_d;
   logic [TAG_W-1:0]   rd_tag_q, rd_tag_d;
   logic [XLEN-1:0]    rem_q, rem_d;           // partial remainder
   logic [XLEN-1:0]    dvd_q, dvd_d;           // dividend, shifted out while quotient bits shift in
   logic [XLEN-1:0]    dvs_q, dvs_d;           // divisor magnitude
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0]    result_q, result_d;
   logic [TAG_W-1:0]   rd_out_q, rd_out_d;

   // Operand conditioning for launch
   logic               signed_op;
   logic               a_neg, b_neg;
   logic [XLEN-1:0]    a_mag, b_mag;
   logic               div_zero, sgn_ovf;

   // Datapath for one restoring step
   logic [XLEN:0]      shifted, diff;
   logic               ge;
   logic [XLEN-1:0]    rem_step, quo_step;
   logic [XLEN-1:0]    quo_fin, rem_fin;

   // Launch decode and the single restoring step, computed from current state
   always_comb begin
      signed_op = ~op[0];
      a_neg     = signed_op & a[XLEN-1];
      b_neg     = signed_op & b[XLEN-1];
      a_mag     = a_neg ? -a : a;
      b_mag     = b_neg ? -b : b;
      div_zero  = (b == '0);
      sgn_ovf   = signed_op && (a == MIN_NEG) && (b == '1);

      // The partial remainder is always below the divisor, so one extra
      // bit is enough to hold the shifted value and detect the borrow.
      shifted   = {rem_q, dvd_q[XLEN-1]};
      diff      = shifted - {1'b0, dvs_q};
      ge        = ~diff[XLEN];
      rem_step  = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      quo_step  = {dvd_q[XLEN-2:0], ge};
      quo_fin   = neg_quo_q ? -quo_step : quo_step;
      rem_fin   = neg_rem_q ? -rem_step : rem_step;
   end

   // Next-state logic for the FSM and all work registers
   always_comb begin
      state_d   = state_q;
      sel_rem_d = sel_rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      rd_tag_d  = rd_tag_q;
      rem_d     = rem_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      rd_out_d  = rd_out_q;

      unique case (state_q)
         S_IDLE: begin
            // kill beats start: a flushed instruction never launches
            if (start && !kill) begin
               if (div_zero) begin
                  result_d = op[1] ? a : '1;
                  rd_out_d = rd_in;
                  state_d  = S_DONE;
               end else if (sgn_ovf) begin
                  result_d = op[1] ? '0 : MIN_NEG;
                  rd_out_d = rd_in;
                  state_d  = S_DONE;
               end else begin
                  sel_rem_d = op[1];
                  neg_quo_d = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
                  rd_tag_d  = rd_in;
                  dvd_d     = a_mag;
                  dvs_d     = b_mag;
                  rem_d     = '0;
                  cnt_d     = '0;
                  state_d   = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (kill) begin
               // Abort leaves result/rd_out as they were
               state_d = S_IDLE;
            end else begin
               rem_d = rem_step;
               dvd_d = quo_step;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  result_d = sel_rem_q ? rem_fin : quo_fin;
                  rd_out_d = rd_tag_q;
                  state_d  = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         sel_rem_q <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         rd_tag_q  <= '0;
         rem_q     <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         rd_out_q  <= '0;
      end else begin
         state_q   <= state_d;
         sel_rem_q <= sel_rem_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         rd_tag_q  <= rd_tag_d;
         rem_q     <= rem_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         rd_out_q  <= rd_out_d;
      end
   end

   assign busy   = (state_q == S_CALC);
   assign done   = (state_q == S_DONE);
   assign result = result_q;
   assign rd_out = rd_out_q;

endmodule

// File: tb/tb_mdu_div_iter.sv
// Self-checking bench for mdu_div_iter: directed scenarios plus randomized operations.
// Expected values come from a plain-arithmetic reference of the RV32M division rules.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_mdu_div_iter;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        kill;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  rd_in;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int checks;
   int errors;
   logic [31:0] last_res;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   mdu_div_iter #(.XLEN(32), .TAG_W(5), .CNT_W(5)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .kill   (kill),
      .op     (op),
      .a      (a),
      .b      (b),
      .rd_in  (rd_in),
      .busy   (busy),
      .done   (done),
      .result (result),
      .rd_out (rd_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: RV32M semantics with SV's truncating signed division
   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [31:0] q;
      logic [31:0] r;
      if (y == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = x;
      end else if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else if (!o[0]) begin
         q = $signed(x) / $signed(y);
         r = $signed(x) % $signed(y);
      end else begin
         q = x / y;
         r = x % y;
      end
      return o[1] ? r : q;
   endfunction

   function automatic int model_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      if (y == 32'd0) return 0;
      if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 0;
      return 32;
   endfunction

   // Launch one op at a falling edge and follow it until done (bounded).
   // Returns at the falling edge where done is seen; dk = -1 if it never came.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] tag, output int bcnt, output int dk,
                         output logic [31:0] res, output logic [4:0] rdo, output int overlap);
      op = o; a = x; b = y; rd_in = tag; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      bcnt = 0; dk = -1; overlap = 0; res = 'x; rdo = 'x;
      for (int k = 0; k < 40; k++) begin
         if (busy) bcnt++;
         if (done) begin
            if (busy) overlap = 1;
            dk  = k;
            res = result;
            rdo = rd_out;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = 2'b00; a = '0; b = '0; rd_in = '0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
      checks++; if (rd_out !== 5'd0) begin errors++; $display("FAIL reset_rd_out got %h exp 0", rd_out); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_divu_basic();
      int bc, dk, ov;
      logic [31:0] res;
      logic [4:0] rdo;
      run_op(OP_DIVU, 32'd100, 32'd7, 5'd9, bc, dk, res, rdo, ov);
      checks++; if (bc !== 32) begin errors++; $display("FAIL divu_busy_cycles got %0d exp 32", bc); end
      checks++; if (dk !== 32) begin errors++; $display("FAIL divu_done_cycle got %0d exp 32", dk); end
      checks++; if (ov !== 0) begin errors++; $display("FAIL divu_busy_during_done got %0d exp 0", ov); end
      checks++; if (res !== 32'd14) begin errors++; $display("FAIL divu_result got %h exp %h", res, 32'd14); end
      checks++; if (rdo !== 5'd9) begin errors++; $display("FAIL divu_rd_out got %h exp %h", rdo, 5'd9); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL divu_done_width got done=%b busy=%b exp 0 0", done, busy); end
      checks++; if (result !== 32'd14) begin errors++; $display("FAIL divu_result_hold got %h exp %h", result, 32'd14); end
      last_res = 32'd14;
   endtask

   task automatic test_signed();
      int bc, dk, ov;
      logic [31:0] res;
      logic [4:0] rdo;
      run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd3, bc, dk, res, rdo, ov);
      checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_neg got %h exp ffffffff", res); end
      @(negedge clk);
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, bc, dk, res, rdo, ov);
      checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg got %h exp fffffffd", res); end
      @(negedge clk);
      run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd5, bc, dk, res, rdo, ov);
      checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_divisor got %h exp fffffffd", res); end
      @(negedge clk);
      last_res = 32'hFFFF_FFFD;
   endtask

   task automatic test_div_zero();
      int bc, dk, ov;
      logic [31:0] res;
      logic [4:0] rdo;
      run_op(OP_DIV, 32'd5, 32'd0, 5'd11, bc, dk, res, rdo, ov);
      checks++; if (dk !== 0) begin errors++; $display("FAIL div0_latency got %0d exp 0", dk); end
      checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_result got %h exp ffffffff", res); end
      checks++; if (rdo !== 5'd11) begin errors++; $display("FAIL div0_rd_out got %h exp %h", rdo, 5'd11); end
      @(negedge clk);
      run_op(OP_REMU, 32'd5, 32'd0, 5'd12, bc, dk, res, rdo, ov);
      checks++; if (res !== 32'd5) begin errors++; $display("FAIL remu0_result got %h exp 5", res); end
      checks++; if (bc !== 0) begin errors++; $display("FAIL remu0_busy got %0d exp 0", bc); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL div0_after got done=%b busy=%b exp 0 0", done, busy); end
      last_res = 32'd5;
   endtask

   task automatic test_overflow();
      int bc, dk, ov;
      logic [31:0] res;
      logic [4:0] rdo;
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, bc, dk, res, rdo, ov);
      checks++; if (dk !== 0 || bc !== 0) begin errors++; $display("FAIL ovf_latency got dk=%0d busy=%0d exp 0 0", dk, bc); end
      checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL ovf_div got %h exp 80000000", res); end
      @(negedge clk);
      run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, bc, dk, res, rdo, ov);
      checks++; if (res !== 32'd0) begin errors++; $display("FAIL ovf_rem got %h exp 0", res); end
      @(negedge clk);
      // Unsigned view of the same operands takes the normal path
      run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, bc, dk, res, rdo, ov);
      checks++; if (res !== 32'd0 || dk !== 32) begin errors++; $display("FAIL ovf_divu got %h dk=%0d exp 0 dk=32", res, dk); end
      @(negedge clk);
      last_res = 32'd0;
   endtask

   task automatic test_kill();
      int bc, dk, ov, seen;
      logic [31:0] res;
      logic [4:0] rdo;
      op = OP_DIVU; a = 32'd1000; b = 32'd3; rd_in = 5'd20; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL kill_busy got %b exp 0", busy); end
      seen = 0;
      for (int k = 0; k < 30; k++) begin
         if (done) seen++;
         @(negedge clk);
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL kill_no_done got %0d pulses exp 0", seen); end
      checks++; if (result !== last_res) begin errors++; $display("FAIL kill_result_kept got %h exp %h", result, last_res); end
      // kill together with start in IDLE blocks the launch
      op = OP_DIVU; a = 32'd50; b = 32'd0; rd_in = 5'd21; start = 1'b1; kill = 1'b1;
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL kill_start got busy=%b done=%b exp 0 0", busy, done); end
      run_op(OP_DIVU, 32'd9, 32'd3, 5'd22, bc, dk, res, rdo, ov);
      checks++; if (res !== 32'd3 || dk !== 32) begin errors++; $display("FAIL kill_next_op got %h dk=%0d exp 3 dk=32", res, dk); end
      // kill during DONE does not cancel the pulse already in progress
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      checks++; if (result !== 32'd3 || rd_out !== 5'd22) begin errors++; $display("FAIL kill_in_done got %h/%h exp 3/16", result, rd_out); end
      last_res = 32'd3;
   endtask

   task automatic test_start_ignored();
      int dk;
      op = OP_DIVU; a = 32'd200; b = 32'd9; rd_in = 5'd6; start = 1'b1;
      @(negedge clk);
      dk = -1;
      for (int k = 0; k < 40; k++) begin
         // start stays high with unrelated operands throughout CALC and DONE
         op = 2'($urandom); a = $urandom; b = 32'd0; rd_in = 5'($urandom);
         if (done) begin dk = k; break; end
         @(negedge clk);
      end
      checks++; if (dk !== 32) begin errors++; $display("FAIL ign_latency got %0d exp 32", dk); end
      checks++; if (result !== 32'd22 || rd_out !== 5'd6) begin errors++; $display("FAIL ign_result got %h/%h exp 16/06", result, rd_out); end
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ign_in_done got busy=%b done=%b exp 0 0", busy, done); end
      last_res = 32'd22;
   endtask

   task automatic test_reset_mid();
      int seen;
      op = OP_DIVU; a = 32'd77; b = 32'd5; rd_in = 5'd8; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_flags got busy=%b done=%b exp 0 0", busy, done); end
      checks++; if (result !== 32'd0 || rd_out !== 5'd0) begin errors++; $display("FAIL rstmid_regs got %h/%h exp 0/0", result, rd_out); end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         if (done || busy) seen++;
         @(negedge clk);
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_done got %0d active cycles exp 0", seen); end
   endtask

   task automatic test_random();
      int bc, dk, ov;
      logic [31:0] res, x, y, exp_res;
      logic [4:0] rdo, tag;
      logic [1:0] o;
      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom);
         x = $urandom;
         y = $urandom;
         tag = 5'($urandom);
         case ($urandom_range(0, 7))
            0: y = 32'd0;
            1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            2: y = 32'($urandom_range(1, 15));
            3: y = -32'($urandom_range(1, 15));
            4: x = 32'($urandom_range(0, 100));
            default: ;
         endcase
         exp_res = model(o, x, y);
         run_op(o, x, y, tag, bc, dk, res, rdo, ov);
         checks++; if (res !== exp_res) begin errors++; $display("FAIL rand_result op=%b a=%h b=%h got %h exp %h", o, x, y, res, exp_res); end
         checks++; if (dk !== model_lat(o, x, y) || rdo !== tag) begin errors++; $display("FAIL rand_timing op=%b a=%h b=%h got dk=%0d rd=%h exp dk=%0d rd=%h", o, x, y, dk, rdo, model_lat(o, x, y), tag); end
         @(negedge clk);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      last_res = 32'd0;
      test_reset();
      test_divu_basic();
      test_signed();
      test_div_zero();
      test_overflow();
      test_kill();
      test_start_ignored();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
